// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM state encodings, the NOP used by flushed registers and the default address width.
package pipe_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_IDLE  = 2'd0,
    PC_FLUSH = 2'd1,
    PC_STALL = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the execute stage, the bus and the
// pipeline controller; the controller sits on the slave side.
interface pipe_ctrl_if #(
  parameter int ADDR_W = pipe_ctrl_pkg::ADDR_W_DEF
);

  logic              jump_en_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              hold_flag_ex_i;
  logic              bus_stall_i;
  logic              jump_en_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic              hold_pc_o;
  logic              hold_if_id_o;
  logic              flush_if_id_o;
  logic              flush_id_ex_o;
  logic              busy_o;
  logic              hold_timeout_o;

  modport master (
    output jump_en_i, jump_addr_i, hold_flag_ex_i, bus_stall_i,
    input  jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o,
           flush_if_id_o, flush_id_ex_o, busy_o, hold_timeout_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, hold_flag_ex_i, bus_stall_i,
    output jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o,
           flush_if_id_o, flush_id_ex_o, busy_o, hold_timeout_o
  );

endinterface

// File: rtl/pipe_ctrl_hold_watchdog.sv
// Saturating count of consecutive hold cycles with a sticky flag that sets
// on the edge where the count reaches HOLD_TIMEOUT.
module hold_watchdog #(
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic timeout
);

  localparam int CNT_W = $clog2(HOLD_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(HOLD_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             timeout_r;

  // hold-cycle counter and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (!hold) begin
        cnt_r <= '0;
      end else if (cnt_r != LIMIT) begin
        cnt_r <= cnt_r + ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      if (hold && (cnt_r == LIMIT - ONE)) begin
        timeout_r <= 1'b1;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

  assign timeout = timeout_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: zero-latency PC redirect with timed flush,
// bus-stall hold with deferred jump replay, and a hold-budget watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int HOLD_TIMEOUT = 1024,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  pc_state_e         state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic              pend_r, pend_nxt_s;
  logic [ADDR_W-1:0] pend_addr_r, pend_addr_nxt_s;

  logic              redirect_s;
  logic [ADDR_W-1:0] redirect_addr_s;
  logic              hold_s;
  logic              flush_if_id_s;
  logic              flush_id_ex_s;
  logic              timeout_s;

  // state, flush count and deferred-jump registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= PC_IDLE;
      cnt_r       <= 4'd0;
      pend_r      <= 1'b0;
      pend_addr_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      pend_r      <= pend_nxt_s;
      pend_addr_r <= pend_addr_nxt_s;
    end
  end

  // next-state and pre-reset-gating outputs; bus stall outranks any jump
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    pend_nxt_s      = pend_r;
    pend_addr_nxt_s = pend_addr_r;
    redirect_s      = 1'b0;
    redirect_addr_s = '0;
    hold_s          = 1'b0;
    flush_if_id_s   = 1'b0;
    flush_id_ex_s   = 1'b0;

    case (state_r)
      PC_IDLE, PC_FLUSH: begin
        if (bus.bus_stall_i) begin
          state_nxt_s = PC_STALL;
          hold_s      = 1'b1;
          if (bus.jump_en_i) begin
            pend_nxt_s      = 1'b1;
            pend_addr_nxt_s = bus.jump_addr_i;
          end else begin
            pend_nxt_s = pend_r;
          end
        end else if (bus.jump_en_i) begin
          redirect_s      = 1'b1;
          redirect_addr_s = bus.jump_addr_i;
        end else if (state_r == PC_FLUSH) begin
          flush_if_id_s = 1'b1;
          flush_id_ex_s = 1'b1;
          if (cnt_r <= 4'd1) begin
            state_nxt_s = PC_IDLE;
            cnt_nxt_s   = 4'd0;
          end else begin
            cnt_nxt_s = cnt_r - 4'd1;
          end
        end else if (bus.hold_flag_ex_i) begin
          // one bubble per cycle into ID/EX while IF/ID and PC freeze
          hold_s        = 1'b1;
          flush_id_ex_s = 1'b1;
        end else begin
          state_nxt_s = PC_IDLE;
        end
      end
      PC_STALL: begin
        if (bus.bus_stall_i) begin
          hold_s = 1'b1;
          if (bus.jump_en_i && !pend_r) begin
            pend_nxt_s      = 1'b1;
            pend_addr_nxt_s = bus.jump_addr_i;
          end else begin
            pend_nxt_s = pend_r;
          end
        end else if (pend_r) begin
          // replay the deferred jump; PC must be free to load the target
          redirect_s      = 1'b1;
          redirect_addr_s = pend_addr_r;
          pend_nxt_s      = 1'b0;
        end else begin
          hold_s      = 1'b1;
          state_nxt_s = PC_IDLE;
        end
      end
      default: begin
        state_nxt_s = PC_IDLE;
        pend_nxt_s  = 1'b0;
      end
    endcase

    if (redirect_s) begin
      flush_if_id_s = 1'b1;
      flush_id_ex_s = 1'b1;
      cnt_nxt_s     = FLUSH_RELOAD;
      state_nxt_s   = (FLUSH_CYCLES == 1) ? PC_IDLE : PC_FLUSH;
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
  end

  hold_watchdog #(
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) u_hold_watchdog (
    .clk    (clk),
    .rst    (rst),
    .hold   (hold_s & ~rst),
    .timeout(timeout_s)
  );

  assign bus.jump_en_o      = redirect_s & ~rst;
  assign bus.jump_addr_o    = rst ? '0 : redirect_addr_s;
  assign bus.hold_pc_o      = hold_s & ~rst;
  assign bus.hold_if_id_o   = hold_s & ~rst;
  assign bus.flush_if_id_o  = flush_if_id_s & ~rst;
  assign bus.flush_id_ex_o  = flush_id_ex_s & ~rst;
  assign bus.busy_o         = ((state_r != PC_IDLE) | pend_r) & ~rst;
  assign bus.hold_timeout_o = timeout_s & ~rst;

endmodule
